cla_top_level: RTL and testbench

Registered carry-lookahead adder (CLA) of parameterised width. It computes A + B + carry-in with hierarchical lookahead carry logic and registers the sum and carry-out. It is the top-level arithmetic block of the adder design and is intended as a place-and-route benchmark for carry-chain timing.

---
 rtl/cla_top_level.sv | 153 +++++++++++++++
 tb/tb_cla_top_level.sv | 128 ++++++++++++
 2 files changed

// File: rtl/cla_top_level.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module   : cla_top_level
//  Purpose  : Registered carry-lookahead adder. Bit g/p, 4-bit CLA blocks and
//             a recursive 4-ary lookahead tree over the blocks. The result
//             {cout, sum} = A + B + cin is captured on an enabled clock edge.
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
module cla_top_level #(
   parameter int DATA_WIDTH = 16          // multiple of 4, >= 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,   // asynchronous, active-low
   input  logic                  i_en,
   input  logic [DATA_WIDTH-1:0] iv_a,
   input  logic [DATA_WIDTH-1:0] iv_b,
   input  logic                  i_cin,
   output logic [DATA_WIDTH-1:0] ov_sum,
   output logic                  o_cout
);

   // Number of lookahead levels above the 4-bit blocks (ceil(log4(n))).
   function automatic int clog4(input int n);
      int lvl;
      int cap;
      lvl = 0;
      cap = 1;
      while (cap < n) begin
         cap = cap * 4;
         lvl = lvl + 1;
      end
      return lvl;
   endfunction

   localparam int NUM_BLK = DATA_WIDTH / 4;
   localparam int LV      = clog4(NUM_BLK);
   // Every tree level is padded to 4*NUM_BLK nodes so that child indices
   // 4*j+m stay in range for all j < NUM_BLK; padding nodes stay zero.
   localparam int PAD     = 4 * NUM_BLK;

   logic [DATA_WIDTH-1:0] bit_g;
   logic [DATA_WIDTH-1:0] bit_p;
   logic [NUM_BLK-1:0]    blk_g;
   logic [NUM_BLK-1:0]    blk_p;
   logic                  lvl_g [0:LV][0:PAD-1];
   logic                  lvl_p [0:LV][0:PAD-1];
   logic                  lvl_c [0:LV][0:PAD-1];
   logic [DATA_WIDTH-1:0] carry;
   logic [DATA_WIDTH-1:0] sum_nxt;
   logic                  cout_nxt;
   logic [DATA_WIDTH-1:0] sum_d;
   logic [DATA_WIDTH-1:0] sum_q;
   logic                  cout_d;
   logic                  cout_q;

   // Bit-level generate/propagate and 4-bit group generate/propagate.
   always_comb begin
      bit_g = iv_a & iv_b;
      bit_p = iv_a ^ iv_b;
      for (int b = 0; b < NUM_BLK; b++) begin
         blk_g[b] = bit_g[4*b+3]
                  | (bit_p[4*b+3] & bit_g[4*b+2])
                  | (bit_p[4*b+3] & bit_p[4*b+2] & bit_g[4*b+1])
                  | (bit_p[4*b+3] & bit_p[4*b+2] & bit_p[4*b+1] & bit_g[4*b]);
         blk_p[b] = &bit_p[4*b +: 4];
      end
   end

   // Lookahead tree: group G/P upwards, then block carries downwards.
   always_comb begin
      for (int l = 0; l <= LV; l++) begin
         for (int j = 0; j < PAD; j++) begin
            lvl_g[l][j] = 1'b0;
            lvl_p[l][j] = 1'b0;
            lvl_c[l][j] = 1'b0;
         end
      end
      for (int j = 0; j < NUM_BLK; j++) begin
         lvl_g[0][j] = blk_g[j];
         lvl_p[0][j] = blk_p[j];
      end
      for (int l = 1; l <= LV; l++) begin
         for (int j = 0; j < NUM_BLK; j++) begin
            lvl_g[l][j] = lvl_g[l-1][4*j+3]
                        | (lvl_p[l-1][4*j+3] & lvl_g[l-1][4*j+2])
                        | (lvl_p[l-1][4*j+3] & lvl_p[l-1][4*j+2] & lvl_g[l-1][4*j+1])
                        | (lvl_p[l-1][4*j+3] & lvl_p[l-1][4*j+2] & lvl_p[l-1][4*j+1]
                           & lvl_g[l-1][4*j]);
            lvl_p[l][j] = lvl_p[l-1][4*j+3] & lvl_p[l-1][4*j+2]
                        & lvl_p[l-1][4*j+1] & lvl_p[l-1][4*j];
         end
      end
      lvl_c[LV][0] = i_cin;
      for (int l = LV; l >= 1; l--) begin
         for (int j = 0; j < NUM_BLK; j++) begin
            lvl_c[l-1][4*j]   = lvl_c[l][j];
            lvl_c[l-1][4*j+1] = lvl_g[l-1][4*j]
                              | (lvl_p[l-1][4*j] & lvl_c[l][j]);
            lvl_c[l-1][4*j+2] = lvl_g[l-1][4*j+1]
                              | (lvl_p[l-1][4*j+1] & lvl_g[l-1][4*j])
                              | (lvl_p[l-1][4*j+1] & lvl_p[l-1][4*j] & lvl_c[l][j]);
            lvl_c[l-1][4*j+3] = lvl_g[l-1][4*j+2]
                              | (lvl_p[l-1][4*j+2] & lvl_g[l-1][4*j+1])
                              | (lvl_p[l-1][4*j+2] & lvl_p[l-1][4*j+1] & lvl_g[l-1][4*j])
                              | (lvl_p[l-1][4*j+2] & lvl_p[l-1][4*j+1] & lvl_p[l-1][4*j]
                                 & lvl_c[l][j]);
         end
      end
   end

   // In-block carries computed directly from the block carry-in, then sum.
   always_comb begin
      for (int b = 0; b < NUM_BLK; b++) begin
         carry[4*b]   = lvl_c[0][b];
         carry[4*b+1] = bit_g[4*b] | (bit_p[4*b] & lvl_c[0][b]);
         carry[4*b+2] = bit_g[4*b+1]
                      | (bit_p[4*b+1] & bit_g[4*b])
                      | (bit_p[4*b+1] & bit_p[4*b] & lvl_c[0][b]);
         carry[4*b+3] = bit_g[4*b+2]
                      | (bit_p[4*b+2] & bit_g[4*b+1])
                      | (bit_p[4*b+2] & bit_p[4*b+1] & bit_g[4*b])
                      | (bit_p[4*b+2] & bit_p[4*b+1] & bit_p[4*b] & lvl_c[0][b]);
      end
      sum_nxt  = bit_p ^ carry;
      cout_nxt = lvl_g[LV][0] | (lvl_p[LV][0] & i_cin);
   end

   // Next-state for the output register: load when enabled, else hold.
   always_comb begin
      sum_d  = sum_q;
      cout_d = cout_q;
      if (i_en) begin
         sum_d  = sum_nxt;
         cout_d = cout_nxt;
      end
   end

   // Output register with asynchronous active-low clear.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         sum_q  <= sum_d;
         cout_q <= cout_d;
      end
   end

   assign ov_sum = sum_q;
   assign o_cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_cla_top_level.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module   : tb_cla_top_level
//  Purpose  : Directed and random self-checking bench for cla_top_level.
//  Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_cla_top_level;

   localparam int DATA_WIDTH = 16;

   logic                  clk;
   logic                  rst_n;
   logic                  en;
   logic [DATA_WIDTH-1:0] a;
   logic [DATA_WIDTH-1:0] b;
   logic                  cin;
   logic [DATA_WIDTH-1:0] sum;
   logic                  cout;

   int n_cmp = 0;
   int n_err = 0;

   cla_top_level #(.DATA_WIDTH(DATA_WIDTH)) dut (
      .i_clk  (clk),
      .i_rst  (rst_n),
      .i_en   (en),
      .iv_a   (a),
      .iv_b   (b),
      .i_cin  (cin),
      .ov_sum (sum),
      .o_cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%05h expected 0x%05h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] res();
      return {15'd0, cout, sum};
   endfunction

   // Drive operands at the falling edge, then check just after the next rising edge.
   task automatic apply(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vc, input logic [16:0] exp);
      @(negedge clk);
      a = va; b = vb; cin = vc;
      @(posedge clk); #1;
      check(tag, res(), {15'd0, exp});
   endtask

   initial begin
      logic [16:0] ref_sum;
      rst_n = 1'b1; en = 1'b0; a = '0; b = '0; cin = 1'b0;

      // Asynchronous reset with random operands and enable high.
      #2;
      a = 16'hBEEF; b = 16'hCAFE; cin = 1'b1; en = 1'b1;
      rst_n = 1'b0;
      #1;
      check("rst_async", res(), 32'h0);
      @(posedge clk); #1;
      check("rst_hold_edge", res(), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      apply("first_add",  16'h1234, 16'h4321, 1'b0, 17'h05555);
      apply("ffff_cin",   16'hFFFF, 16'h0000, 1'b1, 17'h10000);
      apply("7fff_p1",    16'h7FFF, 16'h0001, 1'b0, 17'h08000);
      apply("max_ops",    16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
      apply("msb_ovf",    16'h8000, 16'h8000, 1'b0, 17'h10000);
      apply("cin_only",   16'h0000, 16'h0000, 1'b1, 17'h00001);
      apply("alt_cin",    16'hAAAA, 16'h5555, 1'b1, 17'h10000);
      apply("blk_cross",  16'h0FFF, 16'h0001, 1'b0, 17'h01000);
      apply("load_1000",  16'h0F0F, 16'h00F1, 1'b0, 17'h01000);

      // Enable hold for three edges while operands change.
      @(negedge clk);
      en = 1'b0; a = 16'h0001; b = 16'h0001; cin = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check($sformatf("hold_%0d", k), res(), 32'h01000);
      end
      @(negedge clk);
      en = 1'b1;
      @(posedge clk); #1;
      check("en_resume", res(), 32'h00002);

      // Random regression, each triple held for two cycles.
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
         ref_sum = {1'b0, a} + {1'b0, b} + {16'd0, cin};
         @(posedge clk); #1;
         check($sformatf("rnd%0d_e1", k), res(), {15'd0, ref_sum});
         @(posedge clk); #1;
         check($sformatf("rnd%0d_e2", k), res(), {15'd0, ref_sum});
      end

      // Reset asserted between edges while the output is nonzero.
      apply("pre_rst", 16'h1234, 16'h1111, 1'b0, 17'h02345);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_async", res(), 32'h0);
      @(posedge clk); #1;
      check("mid_rst_edge", res(), 32'h0);
      @(negedge clk);
      rst_n = 1'b1; en = 1'b0;
      @(posedge clk); #1;
      check("rel_no_en", res(), 32'h0);
      @(negedge clk);
      en = 1'b1;
      @(posedge clk); #1;
      check("rel_en", res(), 32'h02345);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
